// File: rtl/simplearm_pkg.sv
// Shared types for the simple multicycle ARM control path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: controller state enum, instruction-class opcodes and the
//           AdrSrc / ALUSrcB / ResultSrc mux encodings.
package simplearm_pkg;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        MEMADR,
        MEMRD,
        MEMWB,
        MEMWR,
        EXECR,
        EXECI,
        ALUWB,
        BRANCH
    } state_t;

    // Instr[27:26] instruction classes
    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    // Memory address source
    localparam logic       ADR_PC     = 1'b0;
    localparam logic       ADR_ALUOUT = 1'b1;

    // ALU A operand source
    localparam logic       SRCA_RD1 = 1'b0;
    localparam logic       SRCA_PC  = 1'b1;

    // ALU B operand source
    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    // Register-file / PC write-back source
    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

endpackage

// File: rtl/multicycle_fsm.sv
// Main controller of the multicycle ARM datapath (Moore FSM, one state per step).
// Latency: LDR 5, STR 4, DP 4, B 3 cycles minimum; FETCH/MEMRD/MEMWR stall on mem_ready.
// Backpressure: mem_req is held until mem_ready; mem_ready is ignored when mem_req=0.
// Ports: clk/reset (async, active high); Op/Funct/Rd instruction fields; CondEx
//        condition-passed; mem_ready/mem_req memory handshake; write enables,
//        datapath mux selects, ALUOp/NoWrite, retire and illegal pulses.
module multicycle_fsm
    import simplearm_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic [3:0] Rd,
    input  logic       CondEx,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       RegW,
    output logic       MemW,
    output logic       AdrSrc,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic       ALUOp,
    output logic       NoWrite,
    output logic       retire,
    output logic       illegal
);

    state_t state;
    state_t next_state;
    logic   dp_nowrite;

    // Funct[2:1] only matter to the ALU decoder, not to sequencing.
    logic   unused_funct;
    assign unused_funct = &{1'b0, Funct[2:1]};

    // CMP/TST: flags only, no register (or PC) write-back
    assign dp_nowrite = (Funct[4:3] == 2'b10);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= FETCH;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            FETCH:  if (mem_ready) next_state = DECODE;
            DECODE: begin
                case (Op)
                    OP_MEM:  next_state = MEMADR;
                    OP_DP:   next_state = Funct[5] ? EXECI : EXECR;
                    OP_BR:   next_state = BRANCH;
                    default: next_state = FETCH;
                endcase
            end
            MEMADR: next_state = Funct[0] ? MEMRD : MEMWR;
            MEMRD:  if (mem_ready) next_state = MEMWB;
            MEMWB:  next_state = FETCH;
            // A store whose condition failed never touches memory
            MEMWR:  if (!CondEx || mem_ready) next_state = FETCH;
            EXECR:  next_state = ALUWB;
            EXECI:  next_state = ALUWB;
            ALUWB:  next_state = FETCH;
            BRANCH: next_state = FETCH;
            default: next_state = FETCH;
        endcase
    end

    always_comb begin
        mem_req   = 1'b0;
        IRWrite   = 1'b0;
        PCWrite   = 1'b0;
        RegW      = 1'b0;
        MemW      = 1'b0;
        AdrSrc    = ADR_PC;
        ALUSrcA   = SRCA_RD1;
        ALUSrcB   = SRCB_RD2;
        ResultSrc = RES_ALUOUT;
        ALUOp     = 1'b0;
        retire    = 1'b0;
        illegal   = 1'b0;
        case (state)
            FETCH: begin
                mem_req   = 1'b1;
                AdrSrc    = ADR_PC;
                ALUSrcA   = SRCA_PC;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
                IRWrite   = mem_ready;
                PCWrite   = mem_ready;
            end
            DECODE: begin
                // PC+8 read for R15 operands
                ALUSrcA   = SRCA_PC;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
                illegal   = (Op == 2'b11);
            end
            MEMADR: begin
                ALUSrcA = SRCA_RD1;
                ALUSrcB = SRCB_IMM;
            end
            MEMRD: begin
                mem_req = 1'b1;
                AdrSrc  = ADR_ALUOUT;
            end
            MEMWB: begin
                ResultSrc = RES_DATA;
                RegW      = CondEx;
                retire    = 1'b1;
            end
            MEMWR: begin
                mem_req = CondEx;
                AdrSrc  = ADR_ALUOUT;
                MemW    = CondEx;
                retire  = !CondEx || mem_ready;
            end
            EXECR: begin
                ALUSrcA = SRCA_RD1;
                ALUSrcB = SRCB_RD2;
                ALUOp   = 1'b1;
            end
            EXECI: begin
                ALUSrcA = SRCA_RD1;
                ALUSrcB = SRCB_IMM;
                ALUOp   = 1'b1;
            end
            ALUWB: begin
                ResultSrc = RES_ALUOUT;
                ALUOp     = 1'b1;
                RegW      = CondEx && !dp_nowrite;
                PCWrite   = CondEx && !dp_nowrite && (Rd == 4'hF);
                retire    = 1'b1;
            end
            BRANCH: begin
                ALUSrcA   = SRCA_RD1;
                ALUSrcB   = SRCB_IMM;
                ResultSrc = RES_ALURESULT;
                PCWrite   = CondEx;
                retire    = 1'b1;
            end
            default: ;
        endcase
        NoWrite = ALUOp && dp_nowrite;
        // State is already FETCH during reset; keep every side effect quiet
        if (reset) begin
            mem_req = 1'b0;
            IRWrite = 1'b0;
            PCWrite = 1'b0;
            RegW    = 1'b0;
            MemW    = 1'b0;
            retire  = 1'b0;
            illegal = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_fsm.sv
// Testbench for multicycle_fsm: instruction-level vector table, hand-written
// reset/stall sequences and randomized instructions against a phase-list model.
module tb_multicycle_fsm;
    import simplearm_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic [3:0] Rd;
    logic       CondEx;
    logic       mem_ready;
    logic       mem_req, IRWrite, PCWrite, RegW, MemW, AdrSrc, ALUSrcA;
    logic [1:0] ALUSrcB, ResultSrc;
    logic       ALUOp, NoWrite, retire, illegal;

    int checks   = 0;
    int failures = 0;

    multicycle_fsm dut (
        .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Rd(Rd),
        .CondEx(CondEx), .mem_ready(mem_ready), .mem_req(mem_req),
        .IRWrite(IRWrite), .PCWrite(PCWrite), .RegW(RegW), .MemW(MemW),
        .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ResultSrc(ResultSrc), .ALUOp(ALUOp), .NoWrite(NoWrite),
        .retire(retire), .illegal(illegal)
    );

    always #5 clk = ~clk;

    // {mem_req, IRWrite, PCWrite, RegW, MemW, retire, illegal}
    function automatic logic [6:0] en_vec();
        return {mem_req, IRWrite, PCWrite, RegW, MemW, retire, illegal};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [6:0] en;
        logic       adr_c;  logic       adr;
        logic       srca_c; logic       srca;
        logic       srcb_c; logic [1:0] srcb;
        logic       res_c;  logic [1:0] res;
        logic       alu_c;
    } exp_t;

    // Expected outputs of one instruction step, straight from the step rules.
    function automatic exp_t expect_of(state_t ph, logic [1:0] op, logic [5:0] fn,
                                       logic [3:0] rd, logic cex, logic mr);
        exp_t e;
        logic nw;
        e  = '0;
        nw = (fn[4:3] == 2'b10);
        case (ph)
            FETCH: begin
                e.en = {1'b1, mr, mr, 4'b0};
                e.adr_c = 1; e.adr = 0; e.srca_c = 1; e.srca = 1;
                e.srcb_c = 1; e.srcb = 2'b10; e.res_c = 1; e.res = 2'b10;
            end
            DECODE: begin
                e.en = {6'b0, op == 2'b11};
                e.srca_c = 1; e.srca = 1; e.srcb_c = 1; e.srcb = 2'b10;
                e.res_c = 1; e.res = 2'b10;
            end
            MEMADR: begin e.srca_c = 1; e.srca = 0; e.srcb_c = 1; e.srcb = 2'b01; end
            MEMRD:  begin e.en = 7'b1000000; e.adr_c = 1; e.adr = 1; end
            MEMWB:  begin e.en = {3'b0, cex, 1'b0, 1'b1, 1'b0}; e.res_c = 1; e.res = 2'b01; end
            MEMWR:  begin
                e.en = {cex, 3'b0, cex, (!cex || mr), 1'b0};
                e.adr_c = 1; e.adr = 1;
            end
            EXECR:  begin e.srca_c = 1; e.srca = 0; e.srcb_c = 1; e.srcb = 2'b00; e.alu_c = 1; end
            EXECI:  begin e.srca_c = 1; e.srca = 0; e.srcb_c = 1; e.srcb = 2'b01; e.alu_c = 1; end
            ALUWB:  begin
                e.en = {2'b0, cex && !nw && rd == 4'hF, cex && !nw, 1'b0, 1'b1, 1'b0};
                e.res_c = 1; e.res = 2'b00; e.alu_c = 1;
            end
            BRANCH: begin
                e.en = {2'b0, cex, 2'b0, 1'b1, 1'b0};
                e.srca_c = 1; e.srca = 0; e.srcb_c = 1; e.srcb = 2'b01;
                e.res_c = 1; e.res = 2'b10;
            end
            default: ;
        endcase
        return e;
    endfunction

    // Runs one instruction starting in FETCH (called at posedge+1).
    // The model is the ordered list of steps the instruction passes through;
    // a step holds while it waits on memory and mem_ready is low.
    task automatic run_instr(input logic [1:0] op, input logic [5:0] fn, input logic [3:0] rd,
                             input logic cex, input int stalls, input bit rnd,
                             output int cyc, output int n_ret, output int n_regw,
                             output int n_memw, output int n_pcw, output int n_irw,
                             output int n_ill);
        state_t plan[$];
        int     idx;
        int     fetches;
        logic   mr;
        logic   waiting;
        exp_t   e;
        plan = '{FETCH, DECODE};
        case (op)
            2'b01: begin
                plan.push_back(MEMADR);
                if (fn[0]) begin plan.push_back(MEMRD); plan.push_back(MEMWB); end
                else plan.push_back(MEMWR);
            end
            2'b00: begin plan.push_back(fn[5] ? EXECI : EXECR); plan.push_back(ALUWB); end
            2'b10: plan.push_back(BRANCH);
            default: ;
        endcase
        idx = 0; fetches = 0; cyc = 0;
        n_ret = 0; n_regw = 0; n_memw = 0; n_pcw = 0; n_irw = 0; n_ill = 0;
        Op = op; Funct = fn; Rd = rd; CondEx = cex;
        while (idx < plan.size()) begin
            if (rnd) mr = ($urandom_range(0, 2) != 0);
            else     mr = !(plan[idx] == FETCH && fetches < stalls);
            if (plan[idx] == FETCH) fetches++;
            mem_ready = mr;
            @(negedge clk);
            e = expect_of(plan[idx], op, fn, rd, cex, mr);
            check("state", 32'(dut.state), 32'(plan[idx]));
            check("enables", 32'(en_vec()), 32'(e.en));
            if (e.adr_c)  check("AdrSrc", 32'(AdrSrc), 32'(e.adr));
            if (e.srca_c) check("ALUSrcA", 32'(ALUSrcA), 32'(e.srca));
            if (e.srcb_c) check("ALUSrcB", 32'(ALUSrcB), 32'(e.srcb));
            if (e.res_c)  check("ResultSrc", 32'(ResultSrc), 32'(e.res));
            if (e.alu_c) begin
                check("ALUOp", 32'(ALUOp), 32'd1);
                check("NoWrite", 32'(NoWrite), 32'(fn[4:3] == 2'b10));
            end
            cyc++;
            n_ret += int'(retire); n_regw += int'(RegW); n_memw += int'(MemW);
            n_pcw += int'(PCWrite); n_irw += int'(IRWrite); n_ill += int'(illegal);
            waiting = !mr && (plan[idx] == FETCH || plan[idx] == MEMRD ||
                              (plan[idx] == MEMWR && cex));
            if (!waiting) idx++;
            @(posedge clk);
            #1;
            if (cyc > 300) begin
                check("cycle_budget", 32'(cyc), 32'd300);
                idx = plan.size();
            end
        end
    endtask

    typedef struct {
        string      name;
        logic [1:0] op;  logic [5:0] fn;  logic [3:0] rd;  logic cex;  int stalls;
        int cyc; int ret; int regw; int memw; int pcw; int irw; int ill;
    } vec_t;

    vec_t tbl[12];
    int   cyc, n_ret, n_regw, n_memw, n_pcw, n_irw, n_ill;

    initial begin
        //           name        op     funct      rd    cex stl  cyc ret regw memw pcw irw ill
        tbl[0]  = '{"fetch_stall", 2'b00, 6'b001000, 4'h3, 1, 3,  7, 1, 1, 0, 1, 1, 0};
        tbl[1]  = '{"ldr",       2'b01, 6'b011001, 4'h2, 1, 0,  5, 1, 1, 0, 1, 1, 0};
        tbl[2]  = '{"ldr_nc",    2'b01, 6'b011001, 4'h2, 0, 0,  5, 1, 0, 0, 1, 1, 0};
        tbl[3]  = '{"str",       2'b01, 6'b011000, 4'h1, 1, 0,  4, 1, 0, 1, 1, 1, 0};
        tbl[4]  = '{"str_nc",    2'b01, 6'b011000, 4'h1, 0, 0,  4, 1, 0, 0, 1, 1, 0};
        tbl[5]  = '{"add_r15",   2'b00, 6'b001000, 4'hF, 1, 0,  4, 1, 1, 0, 2, 1, 0};
        tbl[6]  = '{"add_r3",    2'b00, 6'b001000, 4'h3, 1, 0,  4, 1, 1, 0, 1, 1, 0};
        tbl[7]  = '{"cmp_r15",   2'b00, 6'b010101, 4'hF, 1, 0,  4, 1, 0, 0, 1, 1, 0};
        tbl[8]  = '{"addi",      2'b00, 6'b101000, 4'h2, 1, 0,  4, 1, 1, 0, 1, 1, 0};
        tbl[9]  = '{"b",         2'b10, 6'b000000, 4'h0, 1, 0,  3, 1, 0, 0, 2, 1, 0};
        tbl[10] = '{"b_nc",      2'b10, 6'b000000, 4'h0, 0, 0,  3, 1, 0, 0, 1, 1, 0};
        tbl[11] = '{"illegal",   2'b11, 6'b111111, 4'hF, 1, 0,  2, 0, 0, 0, 1, 1, 1};

        reset = 1'b1; Op = 2'b00; Funct = 6'b0; Rd = 4'h0; CondEx = 1'b0; mem_ready = 1'b1;
        #3;
        check("reset_state", 32'(dut.state), 32'(FETCH));
        check("reset_en", 32'(en_vec()), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_held_en", 32'(en_vec()), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        foreach (tbl[i]) begin
            run_instr(tbl[i].op, tbl[i].fn, tbl[i].rd, tbl[i].cex, tbl[i].stalls, 1'b0,
                      cyc, n_ret, n_regw, n_memw, n_pcw, n_irw, n_ill);
            check({tbl[i].name, "_cycles"}, 32'(cyc), 32'(tbl[i].cyc));
            check({tbl[i].name, "_retire"}, 32'(n_ret), 32'(tbl[i].ret));
            check({tbl[i].name, "_regw"}, 32'(n_regw), 32'(tbl[i].regw));
            check({tbl[i].name, "_memw"}, 32'(n_memw), 32'(tbl[i].memw));
            check({tbl[i].name, "_pcwrite"}, 32'(n_pcw), 32'(tbl[i].pcw));
            check({tbl[i].name, "_irwrite"}, 32'(n_irw), 32'(tbl[i].irw));
            check({tbl[i].name, "_illegal"}, 32'(n_ill), 32'(tbl[i].ill));
        end

        // Reset asserted between edges while a store waits on memory
        Op = 2'b01; Funct = 6'b011000; Rd = 4'h4; CondEx = 1'b1; mem_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 mem_ready = 1'b0;
        @(negedge clk);
        check("memwr_state", 32'(dut.state), 32'(MEMWR));
        check("memwr_en", 32'(en_vec()), 32'b1000100);
        @(posedge clk);
        @(negedge clk);
        check("memwr_stall_state", 32'(dut.state), 32'(MEMWR));
        check("memwr_stall_en", 32'(en_vec()), 32'b1000100);
        #2 reset = 1'b1;
        #1;
        check("midclk_reset_state", 32'(dut.state), 32'(FETCH));
        check("midclk_reset_en", 32'(en_vec()), 32'd0);
        @(posedge clk);
        #1;
        check("reset_edge_en", 32'(en_vec()), 32'd0);
        reset = 1'b0;

        // Random instruction stream, random memory readiness
        for (int k = 0; k < 40; k++) begin
            logic [1:0] rop;
            logic [5:0] rfn;
            logic [3:0] rrd;
            logic       rcx;
            rop = 2'($urandom_range(0, 3));
            rfn = 6'($urandom);
            rrd = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom);
            rcx = 1'($urandom);
            run_instr(rop, rfn, rrd, rcx, 0, 1'b1,
                      cyc, n_ret, n_regw, n_memw, n_pcw, n_irw, n_ill);
            check("rand_retire", 32'(n_ret), 32'(rop != 2'b11));
            check("rand_irwrite", 32'(n_irw), 32'd1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
